dkong_dma: RTL and testbench



---
 rtl/dkong_dma_pkg.sv | 39 +++
 rtl/dkong_dma_regs.sv | 64 ++++++
 rtl/dkong_dma.sv | 142 ++++++++++++++
 tb/tb_dkong_dma.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_dma_pkg.sv
// Shared types and constants for the sprite-copy DMA block.
package dkong_dma_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LEN_W  = 14;

  // CPU register indices (A[3:0])
  localparam logic [IDX_W-1:0] IDX_CH0_ADDR = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_CH0_CNT  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CH1_ADDR = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CH1_CNT  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_MODE     = IDX_W'(8);

  // Mode register bit positions
  localparam int unsigned MODE_EN_BIT     = 0;
  localparam int unsigned MODE_TCSTOP_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_WR,
    ST_NXT
  } state_e;

  // Replace the low or high byte of a 16-bit register
  function automatic logic [ADDR_W-1:0] load_byte(input logic [ADDR_W-1:0] cur,
                                                  input logic              hi,
                                                  input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] r;
    r = cur;
    if (hi) r[ADDR_W-1:DATA_W] = d;
    else    r[DATA_W-1:0]      = d;
    return r;
  endfunction

endpackage

// File: rtl/dkong_dma_regs.sv
// CPU-programmed register file with write-edge detect and shared byte flip-flop.
module dkong_dma_regs
  import dkong_dma_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_ni,
  input  logic              wr_ni,
  input  logic [IDX_W-1:0]  ab_i,
  input  logic [DATA_W-1:0] db_i,
  input  logic              mode_clr_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [DATA_W-1:0] mode_o
);

  logic              sel_q;
  logic              byte_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] cnt0_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] cnt1_q;
  logic [DATA_W-1:0] mode_q;
  logic              sel_now;
  logic              wr_stb;
  logic              unused_cnt1;

  assign sel_now     = cs_ni | wr_ni;
  assign wr_stb      = sel_q & ~sel_now;
  assign unused_cnt1 = ^cnt1_q;

  // Take one register write per falling edge of the combined select/strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q  <= 1'b1;
      byte_q <= 1'b0;
      src_q  <= '0;
      cnt0_q <= '0;
      dst_q  <= '0;
      cnt1_q <= '0;
      mode_q <= '0;
    end else begin
      sel_q <= sel_now;
      if (mode_clr_i) mode_q[MODE_EN_BIT] <= 1'b0;
      if (wr_stb) begin
        case (ab_i)
          IDX_CH0_ADDR: begin src_q  <= load_byte(src_q,  byte_q, db_i); byte_q <= ~byte_q; end
          IDX_CH0_CNT:  begin cnt0_q <= load_byte(cnt0_q, byte_q, db_i); byte_q <= ~byte_q; end
          IDX_CH1_ADDR: begin dst_q  <= load_byte(dst_q,  byte_q, db_i); byte_q <= ~byte_q; end
          IDX_CH1_CNT:  begin cnt1_q <= load_byte(cnt1_q, byte_q, db_i); byte_q <= ~byte_q; end
          IDX_MODE:     begin mode_q <= db_i; byte_q <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  assign src_o  = src_q;
  assign cnt_o  = cnt0_q;
  assign dst_o  = dst_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/dkong_dma.sv
// Sprite-copy DMA: requests the Z80 bus and copies ch0 -> ch1 byte by byte.
module dkong_dma
  import dkong_dma_pkg::*;
(
  input  logic              I_CLK24M,
  input  logic              I_RESET_n,
  input  logic              I_CLK_EN_P,
  input  logic              I_DMA_CS_n,
  input  logic [IDX_W-1:0]  I_AB,
  input  logic [DATA_W-1:0] I_DB,
  input  logic              I_WR_n,
  input  logic              I_DRQ,
  input  logic              I_BUSAK_n,
  input  logic [DATA_W-1:0] I_MDB,
  output logic              O_BUSRQ_n,
  output logic [ADDR_W-1:0] O_MA,
  output logic [DATA_W-1:0] O_MDB,
  output logic              O_MRD_n,
  output logic              O_MWR_n,
  output logic              O_TC,
  output logic              O_BUSY
);

  logic [ADDR_W-1:0] prog_src;
  logic [ADDR_W-1:0] prog_cnt;
  logic [ADDR_W-1:0] prog_dst;
  logic [DATA_W-1:0] prog_mode;
  logic              mode_clr;
  logic              unused_prog;

  state_e            state_q;
  logic              drq_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              busrq_n_q;
  logic              busy_q;
  logic [ADDR_W-1:0] ma_q;
  logic [DATA_W-1:0] mdb_q;
  logic              mrd_n_q;
  logic              mwr_n_q;
  logic              tc_q;

  dkong_dma_regs u_regs (
    .clk_i      (I_CLK24M),
    .rst_ni     (I_RESET_n),
    .cs_ni      (I_DMA_CS_n),
    .wr_ni      (I_WR_n),
    .ab_i       (I_AB),
    .db_i       (I_DB),
    .mode_clr_i (mode_clr),
    .src_o      (prog_src),
    .cnt_o      (prog_cnt),
    .dst_o      (prog_dst),
    .mode_o     (prog_mode)
  );

  // Terminal count with TC-stop set disarms the channel as the block returns to idle
  assign mode_clr = I_CLK_EN_P && (state_q == ST_NXT) && (cnt_q == '0)
                    && prog_mode[MODE_TCSTOP_BIT];

  // Count bits above the transfer length and spare mode bits are stored but have no effect
  assign unused_prog = ^{prog_cnt[ADDR_W-1:LEN_W], prog_mode};

  // Transfer state machine; strobes, address and data are registered per enable period
  always_ff @(posedge I_CLK24M or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state_q   <= ST_IDLE;
      drq_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      busrq_n_q <= 1'b1;
      busy_q    <= 1'b0;
      ma_q      <= '0;
      mdb_q     <= '0;
      mrd_n_q   <= 1'b1;
      mwr_n_q   <= 1'b1;
      tc_q      <= 1'b0;
    end else if (I_CLK_EN_P) begin
      drq_q   <= I_DRQ;
      ma_q    <= '0;
      mdb_q   <= '0;
      mrd_n_q <= 1'b1;
      mwr_n_q <= 1'b1;
      tc_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (I_DRQ && !drq_q && prog_mode[MODE_EN_BIT]) begin
            state_q   <= ST_REQ;
            busrq_n_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!I_BUSAK_n) begin
            state_q <= ST_RD;
            src_q   <= prog_src;
            dst_q   <= prog_dst;
            cnt_q   <= prog_cnt[LEN_W-1:0];
            ma_q    <= prog_src;
            mrd_n_q <= 1'b0;
          end
        end
        ST_RD: begin
          state_q <= ST_WR;
          ma_q    <= dst_q;
          mdb_q   <= I_MDB;
          mwr_n_q <= 1'b0;
        end
        ST_WR: begin
          state_q <= ST_NXT;
          tc_q    <= (cnt_q == '0);
        end
        ST_NXT: begin
          src_q <= src_q + ADDR_W'(1);
          dst_q <= dst_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            state_q   <= ST_IDLE;
            busrq_n_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            state_q <= ST_RD;
            cnt_q   <= cnt_q - LEN_W'(1);
            ma_q    <= src_q + ADDR_W'(1);
            mrd_n_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign O_BUSRQ_n = busrq_n_q;
  assign O_BUSY    = busy_q;
  assign O_MA      = ma_q;
  assign O_MDB     = mdb_q;
  assign O_MRD_n   = mrd_n_q;
  assign O_MWR_n   = mwr_n_q;
  assign O_TC      = tc_q;

endmodule

// File: tb/tb_dkong_dma.sv
// Bench for dkong_dma: table-driven transfers, corner sequences and random copies vs a memory model.
module tb_dkong_dma;

  logic        I_CLK24M = 1'b0;
  logic        I_RESET_n = 1'b1;
  logic        I_CLK_EN_P = 1'b0;
  logic        I_DMA_CS_n = 1'b1;
  logic [3:0]  I_AB = '0;
  logic [7:0]  I_DB = '0;
  logic        I_WR_n = 1'b1;
  logic        I_DRQ = 1'b0;
  logic        I_BUSAK_n = 1'b1;
  logic [7:0]  I_MDB;
  logic        O_BUSRQ_n, O_MRD_n, O_MWR_n, O_TC, O_BUSY;
  logic [15:0] O_MA;
  logic [7:0]  O_MDB;

  logic [7:0]  mem  [65536];
  logic [7:0]  refm [65536];
  logic [15:0] rd_q [$];
  logic [15:0] wr_q [$];
  int unsigned pass_cnt = 0, check_cnt = 0;
  int unsigned viol_cnt = 0, tc_cnt = 0, busrq_cnt = 0;

  typedef struct {
    logic [15:0] src;
    logic [15:0] cnt;
    logic [15:0] dst;
    logic [7:0]  mode;
    int unsigned dly;
    int unsigned exp_n;
    logic [15:0] exp_last_rd;
    logic [15:0] exp_last_wr;
    int unsigned exp_bus;
  } vec_t;

  vec_t vecs [5];

  dkong_dma dut (
    .I_CLK24M   (I_CLK24M),
    .I_RESET_n  (I_RESET_n),
    .I_CLK_EN_P (I_CLK_EN_P),
    .I_DMA_CS_n (I_DMA_CS_n),
    .I_AB       (I_AB),
    .I_DB       (I_DB),
    .I_WR_n     (I_WR_n),
    .I_DRQ      (I_DRQ),
    .I_BUSAK_n  (I_BUSAK_n),
    .I_MDB      (I_MDB),
    .O_BUSRQ_n  (O_BUSRQ_n),
    .O_MA       (O_MA),
    .O_MDB      (O_MDB),
    .O_MRD_n    (O_MRD_n),
    .O_MWR_n    (O_MWR_n),
    .O_TC       (O_TC),
    .O_BUSY     (O_BUSY)
  );

  // Memory answers reads at whatever address the DMA drives
  assign I_MDB = mem[O_MA];

  initial forever #20 I_CLK24M = ~I_CLK24M;

  // One-in-eight clock enable
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge I_CLK24M);
      c = (c + 1) % 8;
      I_CLK_EN_P = (c == 0);
    end
  end

  // Bus monitor: records strobes, performs memory writes, flags illegal output combinations
  initial forever begin
    @(posedge I_CLK24M);
    if (I_CLK_EN_P) begin
      #1;
      if (!O_MRD_n && !O_MWR_n) viol_cnt++;
      if (O_MRD_n && O_MWR_n && O_MA != 16'h0) viol_cnt++;
      if (O_MWR_n && O_MDB != 8'h0) viol_cnt++;
      if (O_BUSY == O_BUSRQ_n) viol_cnt++;
      if (!O_MRD_n) rd_q.push_back(O_MA);
      if (!O_MWR_n) begin
        wr_q.push_back(O_MA);
        mem[O_MA] = O_MDB;
      end
      if (O_TC) begin
        tc_cnt++;
        if (O_BUSRQ_n) viol_cnt++;
      end
      if (!O_BUSRQ_n) busrq_cnt++;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic wait_en();
    do @(posedge I_CLK24M); while (!I_CLK_EN_P);
    #2;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge I_CLK24M);
    I_AB = a; I_DB = d; I_DMA_CS_n = 1'b0; I_WR_n = 1'b0;
    @(negedge I_CLK24M);
    @(negedge I_CLK24M);
    I_WR_n = 1'b1; I_DMA_CS_n = 1'b1;
    @(negedge I_CLK24M);
  endtask

  // Index 5 is unmapped; slipping it between the two source bytes must not disturb the byte order
  task automatic prog(input logic [15:0] src, input logic [15:0] cnt,
                      input logic [15:0] dst, input logic [7:0] mode);
    cpu_wr(4'd0, src[7:0]);
    cpu_wr(4'd5, 8'hFF);
    cpu_wr(4'd0, src[15:8]);
    cpu_wr(4'd1, cnt[7:0]);
    cpu_wr(4'd1, cnt[15:8]);
    cpu_wr(4'd2, dst[7:0]);
    cpu_wr(4'd2, dst[15:8]);
    cpu_wr(4'd3, 8'h5A);
    cpu_wr(4'd3, 8'hA5);
    cpu_wr(4'd8, mode);
  endtask

  task automatic clear_mon();
    rd_q.delete(); wr_q.delete();
    tc_cnt = 0; busrq_cnt = 0;
  endtask

  task automatic start_xfer(input int unsigned dly);
    int unsigned n;
    I_DRQ = 1'b0;
    wait_en(); wait_en();
    I_DRQ = 1'b1;
    n = 0;
    while (O_BUSRQ_n && n < 20) begin wait_en(); n++; end
    chk("bus request", 32'(O_BUSRQ_n), 32'd0);
    repeat (dly) wait_en();
    I_BUSAK_n = 1'b0;
  endtask

  task automatic finish_xfer();
    int unsigned n;
    n = 0;
    while (!O_BUSRQ_n && n < 5000) begin wait_en(); n++; end
    chk("bus release", 32'(O_BUSRQ_n), 32'd1);
    I_BUSAK_n = 1'b1;
    I_DRQ = 1'b0;
  endtask

  // Reference: a sequential byte copy of (count[13:0]+1) bytes with 16-bit address wrap
  task automatic check_xfer(input string tag, input logic [15:0] src, input logic [15:0] cnt,
                            input logic [15:0] dst, input int unsigned dly);
    int unsigned n, rd_err, wr_err, mem_err;
    logic [15:0] s, d;
    n = 32'(cnt[13:0]) + 32'd1;
    rd_err = 0; wr_err = 0; mem_err = 0;
    for (int i = 0; i < int'(n); i++) begin
      s = src + 16'(i);
      d = dst + 16'(i);
      refm[d] = refm[s];
      if (i >= rd_q.size() || rd_q[i] != s) rd_err++;
      if (i >= wr_q.size() || wr_q[i] != d) wr_err++;
    end
    for (int a = 0; a < 65536; a++) if (mem[a] != refm[a]) mem_err++;
    chk({tag, " rd count"}, 32'(rd_q.size()), n);
    chk({tag, " wr count"}, 32'(wr_q.size()), n);
    chk({tag, " rd order errs"}, rd_err, 32'd0);
    chk({tag, " wr order errs"}, wr_err, 32'd0);
    chk({tag, " mem diffs"}, mem_err, 32'd0);
    chk({tag, " tc pulses"}, tc_cnt, 32'd1);
    chk({tag, " busrq enables"}, busrq_cnt, 32'd1 + dly + 32'd3 * n);
  endtask

  initial begin
    logic [15:0] last_rd, last_wr, rs, rc, rd;
    logic [7:0]  rm;
    int unsigned dl, snap, n;

    vecs[0] = '{16'h6900, 16'h017F, 16'h7000, 8'h01,  2, 384, 16'h6A7F, 16'h717F, 1155};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'h1000, 8'h01,  0,   2, 16'h0000, 16'h1001,    7};
    vecs[2] = '{16'h1234, 16'hC002, 16'h4000, 8'h01,  1,   3, 16'h1236, 16'h4002,   11};
    vecs[3] = '{16'h0100, 16'h0000, 16'h0200, 8'h01, 50,   1, 16'h0100, 16'h0200,   54};
    vecs[4] = '{16'h3000, 16'h0004, 16'hFFFE, 8'h41,  3,   5, 16'h3004, 16'h0002,   19};

    for (int a = 0; a < 65536; a++) begin
      mem[a]  = 8'($urandom);
      refm[a] = mem[a];
    end

    // Reset values
    #5 I_RESET_n = 1'b0;
    #100;
    chk("reset busrq_n", 32'(O_BUSRQ_n), 32'd1);
    chk("reset mrd_n",   32'(O_MRD_n),   32'd1);
    chk("reset mwr_n",   32'(O_MWR_n),   32'd1);
    chk("reset ma",      32'(O_MA),      32'd0);
    chk("reset mdb",     32'(O_MDB),     32'd0);
    chk("reset tc",      32'(O_TC),      32'd0);
    chk("reset busy",    32'(O_BUSY),    32'd0);
    #13 I_RESET_n = 1'b1;
    repeat (2) wait_en();

    // Table-driven transfers
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      prog(vecs[i].src, vecs[i].cnt, vecs[i].dst, vecs[i].mode);
      start_xfer(vecs[i].dly);
      finish_xfer();
      last_rd = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 16'h0;
      last_wr = (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 16'h0;
      chk($sformatf("vec%0d bytes", i), 32'(rd_q.size()), vecs[i].exp_n);
      chk($sformatf("vec%0d last rd", i), 32'(last_rd), 32'(vecs[i].exp_last_rd));
      chk($sformatf("vec%0d last wr", i), 32'(last_wr), 32'(vecs[i].exp_last_wr));
      chk($sformatf("vec%0d bus hold", i), busrq_cnt, vecs[i].exp_bus);
      check_xfer($sformatf("vec%0d", i), vecs[i].src, vecs[i].cnt, vecs[i].dst, vecs[i].dly);
    end

    // TC-stop disarmed the channel: a fresh DRQ edge must not request the bus
    snap = busrq_cnt;
    I_DRQ = 1'b0; wait_en(); wait_en();
    I_DRQ = 1'b1;
    repeat (10) wait_en();
    chk("tcstop drq ignored", busrq_cnt - snap, 32'd0);
    I_DRQ = 1'b0;

    // Reset during the write of byte 5; nothing restarts until reprogrammed
    clear_mon();
    prog(16'h5000, 16'h0013, 16'h5800, 8'h01);
    start_xfer(0);
    n = 0;
    while (wr_q.size() < 5 && n < 100) begin wait_en(); n++; end
    chk("mid rst at wr5", 32'(O_MWR_n), 32'd0);
    I_RESET_n = 1'b0;
    #1;
    chk("mid rst busrq_n", 32'(O_BUSRQ_n), 32'd1);
    chk("mid rst mrd_n",   32'(O_MRD_n),   32'd1);
    chk("mid rst mwr_n",   32'(O_MWR_n),   32'd1);
    chk("mid rst ma",      32'(O_MA),      32'd0);
    chk("mid rst mdb",     32'(O_MDB),     32'd0);
    chk("mid rst tc",      32'(O_TC),      32'd0);
    chk("mid rst busy",    32'(O_BUSY),    32'd0);
    #100 I_RESET_n = 1'b1;
    I_BUSAK_n = 1'b0;
    for (int i = 0; i < 5; i++) refm[16'h5800 + 16'(i)] = refm[16'h5000 + 16'(i)];
    snap = busrq_cnt;
    I_DRQ = 1'b0; wait_en(); wait_en();
    I_DRQ = 1'b1;
    repeat (20) wait_en();
    chk("post rst reads", 32'(rd_q.size()), 32'd5);
    chk("post rst writes", 32'(wr_q.size()), 32'd5);
    chk("post rst busrq", busrq_cnt - snap, 32'd0);
    chk("post rst tc", tc_cnt, 32'd0);
    I_DRQ = 1'b0;
    I_BUSAK_n = 1'b1;

    // CPU writes mid-transfer leave the working copy alone; a mode write realigns the byte flip-flop
    clear_mon();
    prog(16'h2000, 16'h0009, 16'h2800, 8'h01);
    start_xfer(1);
    n = 0;
    while (wr_q.size() < 3 && n < 100) begin wait_en(); n++; end
    cpu_wr(4'd0, 8'hAA);
    cpu_wr(4'd8, 8'h01);
    finish_xfer();
    check_xfer("midwr", 16'h2000, 16'h0009, 16'h2800, 1);
    clear_mon();
    cpu_wr(4'd0, 8'h10);
    cpu_wr(4'd0, 8'h21);
    cpu_wr(4'd1, 8'h01);
    cpu_wr(4'd1, 8'h00);
    cpu_wr(4'd2, 8'h00);
    cpu_wr(4'd2, 8'h30);
    cpu_wr(4'd8, 8'h01);
    start_xfer(0);
    finish_xfer();
    chk("realign first rd", 32'((rd_q.size() > 0) ? rd_q[0] : 16'h0), 32'h2110);
    check_xfer("realign", 16'h2110, 16'h0001, 16'h3000, 0);

    // Randomized transfers against the copy model
    for (int t = 0; t < 8; t++) begin
      rs = 16'($urandom);
      rd = 16'($urandom);
      rc = (16'($urandom_range(0, 3)) << 14) | 16'($urandom_range(0, 40));
      rm = ($urandom_range(0, 1) == 1) ? 8'h41 : 8'h01;
      dl = $urandom_range(0, 5);
      clear_mon();
      prog(rs, rc, rd, rm);
      start_xfer(dl);
      finish_xfer();
      check_xfer($sformatf("rnd%0d", t), rs, rc, rd, dl);
    end

    chk("output invariants", viol_cnt, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
